// File: rtl/types.sv
// Shared NoC flit types and the checksum width used across the router.
package types;

  typedef logic [7:0] checksum_t;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } flittype;

  typedef struct packed {
    flittype   flit_type;
    logic [7:0]  header;
    logic [31:0] payload;
    checksum_t   checksum;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

endpackage

// File: rtl/calculate_checksum_comb.sv
// Combinational checksum unit: byte-wise XOR over type, header and payload.
// flit_out carries the input flit with the freshly computed checksum inserted.
module calculate_checksum_comb
  import types::*;
(
  input  flit_t     flit_in,
  output checksum_t checksum,
  output logic      is_valid,
  output flit_t     flit_out
);

  checksum_t sum;

  // XOR-fold every non-checksum byte, then compare and insert.
  always_comb begin
    sum = {6'b0, flit_in.flit_type}
        ^ flit_in.header
        ^ flit_in.payload[31:24]
        ^ flit_in.payload[23:16]
        ^ flit_in.payload[15:8]
        ^ flit_in.payload[7:0];
    checksum          = sum;
    is_valid          = (sum == flit_in.checksum);
    flit_out          = flit_in;
    flit_out.checksum = sum;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: scans from ptr upward (wrapping) and grants
// the first requester. Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int            idx;
  logic [IW-1:0] idx_w;

  // First pending request at or after ptr wins; nothing when disabled.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_w = IW'(idx);
      if (enable && !grant_any && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/checksum_unit_arbiter.sv
// Shares one checksum unit among NUM_PORTS requesters. A round-robin grant
// feeds the unit; the result lands in a single valid/ready output register.
//
// Handshake: a request transfers on req_valid[i] & req_ready[i]; req_ready
// is only raised when the output stage is free (empty or being popped this
// cycle), and the result transfers downstream on out_valid & out_ready.
module checksum_unit_arbiter
  import types::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int ERR_CNT_W = 16,
  localparam int PORT_ID_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     req_valid,
  input  flit_t [NUM_PORTS-1:0]    req_flit,
  input  logic [NUM_PORTS-1:0]     req_gen,
  output logic [NUM_PORTS-1:0]     req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output flit_t                    out_flit,
  output logic [PORT_ID_W-1:0]     out_port,
  output logic                     out_ok,
  input  logic                     err_clear,
  output logic [ERR_CNT_W-1:0]     err_count
);

  logic                 stage_free;
  logic [PORT_ID_W-1:0] ptr_q;
  logic [PORT_ID_W-1:0] ptr_next;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_ID_W-1:0] grant_idx;
  logic                 grant_any;
  flit_t                sel_flit;
  logic                 sel_gen;
  checksum_t            calc_sum;
  logic                 calc_ok;
  flit_t                calc_flit;
  logic                 bad_check;

  // Grants are held off during reset so nothing looks accepted then.
  assign stage_free = !out_valid || out_ready;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .enable    (stage_free && !rst),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Steer the granted requester's flit and mode into the shared unit.
  always_comb begin
    sel_flit = req_flit[grant_idx];
    sel_gen  = req_gen[grant_idx];
  end

  calculate_checksum_comb u_calc (
    .flit_in  (sel_flit),
    .checksum (calc_sum),
    .is_valid (calc_ok),
    .flit_out (calc_flit)
  );

  // Pointer moves one past the winner; unchanged when nobody is granted.
  always_comb begin
    ptr_next = ptr_q;
    if (grant_any) begin
      if (grant_idx == PORT_ID_W'(NUM_PORTS - 1)) ptr_next = '0;
      else                                        ptr_next = grant_idx + PORT_ID_W'(1);
    end
  end

  assign bad_check = grant_any && !sel_gen && !calc_ok;

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_next;
  end

  // Output stage: load on transfer, drain on pop, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_port  <= '0;
      out_ok    <= 1'b0;
    end else if (grant_any) begin
      out_valid <= 1'b1;
      out_port  <= grant_idx;
      out_flit  <= sel_gen ? calc_flit : sel_flit;
      out_ok    <= sel_gen || calc_ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating failure counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (bad_check && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
